fetch_queue_stage: RTL and testbench

Parametrised next-generation fetch stage. It generates the PC, issues pipelined in-order requests to instruction memory, and tags each request with the branch prediction made for its PC. Returned instructions are buffered in a fetch queue that decouples I-memory latency from decode. It sits between the I-memory port and the IF/ID boundary, and replaces the single-entry stall/flush fetch with a credit-based queue plus a redirect-drain mechanism.

---
 rtl/fetch_queue_stage_if.sv | 42 ++++
 rtl/fetch_queue_stage.sv | 111 +++++++++++
 tb/tb_fetch_queue_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bus bundle: I-memory request/response, branch predictor lookup,
// EX redirect and the fetch-queue head presented to decode.
interface fetch_queue_stage_if #(
  parameter int XLEN   = 32,
  parameter int GHSR_W = 8,
  parameter int CNT_W  = 3
);
  logic              imem_req;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_gnt;
  logic              imem_resp;
  logic [31:0]       imem_data;
  logic [XLEN-1:0]   bp_pc;
  logic              bp_hit;
  logic              bp_taken;
  logic [XLEN-1:0]   bp_target;
  logic [GHSR_W-1:0] bp_ghsr;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              fq_valid;
  logic              fq_ready;
  logic [XLEN-1:0]   fq_pc;
  logic [31:0]       fq_instr;
  logic              fq_pred_taken;
  logic [XLEN-1:0]   fq_pred_target;
  logic [GHSR_W-1:0] fq_ghsr;
  logic [CNT_W-1:0]  fq_count;

  modport master (
    output imem_req, imem_req_addr, bp_pc, fq_valid, fq_pc, fq_instr,
           fq_pred_taken, fq_pred_target, fq_ghsr, fq_count,
    input  imem_gnt, imem_resp, imem_data, bp_hit, bp_taken, bp_target,
           bp_ghsr, redirect_valid, redirect_pc, fq_ready
  );

  modport slave (
    input  imem_req, imem_req_addr, bp_pc, fq_valid, fq_pc, fq_instr,
           fq_pred_taken, fq_pred_target, fq_ghsr, fq_count,
    output imem_gnt, imem_resp, imem_data, bp_hit, bp_taken, bp_target,
           bp_ghsr, redirect_valid, redirect_pc, fq_ready
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Credit-based fetch stage: PC generation, pipelined I-mem requests tagged with
// predictions, and a fetch queue with redirect drain. FETCH_FQ_BYPASS_EN enables empty-queue bypass.
module fetch_queue_stage #(
  parameter int              XLEN            = 32,
  parameter int              FQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter int              GHSR_W          = 8,
  parameter logic [XLEN-1:0] PC_INIT         = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  fetch_queue_stage_if.master bus
);
  localparam int CNT_W  = $clog2(FQ_DEPTH + 1);
  localparam int PTR_W  = $clog2(FQ_DEPTH);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int MPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int META_W = 2 * XLEN + 1 + GHSR_W;
  localparam int ENT_W  = META_W + 32;

  logic [XLEN-1:0]   pc_reg;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  drop_cnt;
  logic [META_W-1:0] meta_mem [MAX_OUTSTANDING];
  logic [MPTR_W-1:0] meta_wr;
  logic [MPTR_W-1:0] meta_rd;
  logic [ENT_W-1:0]  fq_mem [FQ_DEPTH];
  logic [PTR_W-1:0]  fq_wr;
  logic [PTR_W-1:0]  fq_rd;
  logic [CNT_W-1:0]  fq_cnt;

  logic              pred_taken;
  logic              req;
  logic              grant;
  logic              resp_vld;
  logic              keep;
  logic              head_valid;
  logic              bypass;
  logic              fq_push;
  logic              fq_pop;
  logic [ENT_W-1:0]  resp_ent;
  logic [ENT_W-1:0]  out_ent;

  function automatic logic [MPTR_W-1:0] mptr_inc(input logic [MPTR_W-1:0] p);
    return (p == MPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + MPTR_W'(1);
  endfunction

  // Credits count in-flight requests against free queue slots, so a response always has room.
  assign pred_taken = bus.bp_hit & bus.bp_taken;
  assign req        = reset_n & ~bus.redirect_valid
                    & (32'(outstanding) < MAX_OUTSTANDING)
                    & ((32'(outstanding) + 32'(fq_cnt)) < FQ_DEPTH);
  assign grant      = req & bus.imem_gnt;
  assign resp_vld   = bus.imem_resp & (outstanding != '0);
  assign keep       = resp_vld & (drop_cnt == '0) & ~bus.redirect_valid;
  assign head_valid = (fq_cnt != '0);
  assign resp_ent   = {meta_mem[meta_rd], bus.imem_data};

`ifdef FETCH_FQ_BYPASS_EN
  assign bypass = keep & ~head_valid & bus.fq_ready;
`else
  assign bypass = 1'b0;
`endif

  assign fq_push = keep & ~bypass;
  assign fq_pop  = head_valid & bus.fq_ready;
  assign out_ent = bypass ? resp_ent : (head_valid ? fq_mem[fq_rd] : '0);

  assign bus.imem_req      = req;
  assign bus.imem_req_addr = pc_reg;
  assign bus.bp_pc         = pc_reg;
  assign bus.fq_valid      = head_valid | bypass;
  assign bus.fq_count      = fq_cnt;
  assign {bus.fq_pc, bus.fq_pred_taken, bus.fq_pred_target, bus.fq_ghsr, bus.fq_instr} = out_ent;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg      <= PC_INIT;
      outstanding <= '0;
      drop_cnt    <= '0;
      meta_wr     <= '0;
      meta_rd     <= '0;
      fq_wr       <= '0;
      fq_rd       <= '0;
      fq_cnt      <= '0;
    end else begin
      outstanding <= outstanding + OUT_W'(grant) - OUT_W'(resp_vld);
      if (grant)    meta_wr <= mptr_inc(meta_wr);
      if (resp_vld) meta_rd <= mptr_inc(meta_rd);
      if (bus.redirect_valid) begin
        // Everything still in flight belongs to the wrong path.
        pc_reg   <= bus.redirect_pc;
        fq_wr    <= '0;
        fq_rd    <= '0;
        fq_cnt   <= '0;
        drop_cnt <= outstanding - OUT_W'(resp_vld);
      end else begin
        if (grant) pc_reg <= pred_taken ? bus.bp_target : pc_reg + XLEN'(4);
        if (resp_vld && drop_cnt != '0) drop_cnt <= drop_cnt - OUT_W'(1);
        if (fq_push) fq_wr <= fq_wr + PTR_W'(1);
        if (fq_pop)  fq_rd <= fq_rd + PTR_W'(1);
        fq_cnt <= fq_cnt + CNT_W'(fq_push) - CNT_W'(fq_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant)   meta_mem[meta_wr] <= {pc_reg, pred_taken, bus.bp_target, bus.bp_ghsr};
    if (fq_push) fq_mem[fq_wr]     <= resp_ent;
  end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: in-order memory model with epoch tagging,
// predictor table, and a scoreboard of expected fetch-queue entries.
module tb_fetch_queue_stage;
  localparam int          XLEN     = 32;
  localparam int          FQ_DEPTH = 4;
  localparam int          MAX_OUT  = 2;
  localparam int          GHSR_W   = 8;
  localparam int          CNT_W    = $clog2(FQ_DEPTH + 1);
  localparam logic [31:0] PC_INIT  = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
    logic        taken;
    logic [31:0] tgt;
    logic [7:0]  ghsr;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] tgt;
    logic [7:0]  ghsr;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fetch_queue_stage_if #(.XLEN(XLEN), .GHSR_W(GHSR_W), .CNT_W(CNT_W)) bus ();

  fetch_queue_stage #(
    .XLEN(XLEN), .FQ_DEPTH(FQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT),
    .GHSR_W(GHSR_W), .PC_INIT(PC_INIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  mreq_t       mem_q[$];
  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          out_m = 0;
  logic [31:0] pc_m = PC_INIT;
  logic        gnt_en = 1'b1;
  logic        bp_en = 1'b0;
  logic [31:0] hit_pc = 32'h8;
  logic [31:0] hit_tgt = 32'h100;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [7:0] ghsr_of(input logic [31:0] a);
    return a[9:2] ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed timeout expected condition", tag);
  endtask

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic cycle();
    logic resp, kept, exp_req, exp_valid, redir, hit;
    int   sb_n;
    exp_t head;
    redir = bus.redirect_valid;
    resp  = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    bus.imem_resp = resp;
    bus.imem_data = resp ? instr_of(mem_q[0].addr) : 32'h0;
    bus.imem_gnt  = gnt_en;
    hit = bp_en && (pc_m == hit_pc);
    bus.bp_hit    = hit;
    bus.bp_taken  = hit;
    bus.bp_target = hit_tgt;
    bus.bp_ghsr   = ghsr_of(pc_m);
    #1;
    sb_n    = sb.size();
    exp_req = !redir && (out_m < MAX_OUT) && ((out_m + sb_n) < FQ_DEPTH);
    check("imem_req", 64'(bus.imem_req), 64'(exp_req));
    check("fq_count", 64'(bus.fq_count), 64'(sb_n));
    kept = resp && (mem_q[0].epoch == epoch) && !redir;
    exp_valid = (sb_n != 0);
`ifdef FETCH_FQ_BYPASS_EN
    if (kept && sb_n == 0 && bus.fq_ready) exp_valid = 1'b1;
`endif
    check("fq_valid", 64'(bus.fq_valid), 64'(exp_valid));
    if (kept)
      sb.push_back('{pc: mem_q[0].addr, instr: instr_of(mem_q[0].addr),
                     taken: mem_q[0].taken, tgt: mem_q[0].tgt, ghsr: mem_q[0].ghsr});
    if (resp) begin
      void'(mem_q.pop_front());
      out_m--;
    end
    if (exp_valid && bus.fq_ready) begin
      head = sb.pop_front();
      check("fq_pc", 64'(bus.fq_pc), 64'(head.pc));
      check("fq_instr", 64'(bus.fq_instr), 64'(head.instr));
      check("fq_pred_taken", 64'(bus.fq_pred_taken), 64'(head.taken));
      check("fq_pred_target", 64'(bus.fq_pred_target), 64'(head.tgt));
      check("fq_ghsr", 64'(bus.fq_ghsr), 64'(head.ghsr));
    end
    if (exp_req && gnt_en) begin
      check("imem_req_addr", 64'(bus.imem_req_addr), 64'(pc_m));
      check("bp_pc", 64'(bus.bp_pc), 64'(pc_m));
      mem_q.push_back('{addr: pc_m, due: cyc + lat, epoch: epoch,
                        taken: hit, tgt: hit_tgt, ghsr: ghsr_of(pc_m)});
      out_m++;
      pc_m = hit ? hit_tgt : pc_m + 32'd4;
    end
    if (redir) begin
      sb.delete();
      epoch++;
      pc_m = bus.redirect_pc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    cycle();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.imem_gnt       = 1'b0;
    bus.imem_resp      = 1'b0;
    bus.imem_data      = 32'h0;
    bus.bp_hit         = 1'b0;
    bus.bp_taken       = 1'b0;
    bus.bp_target      = 32'h0;
    bus.bp_ghsr        = 8'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.fq_ready       = 1'b1;

    #12;
    check("rst_imem_req", 64'(bus.imem_req), 64'(0));
    check("rst_fq_valid", 64'(bus.fq_valid), 64'(0));
    check("rst_fq_count", 64'(bus.fq_count), 64'(0));
    check("rst_fq_pc", 64'(bus.fq_pc), 64'(0));
    check("rst_fq_instr", 64'(bus.fq_instr), 64'(0));
    check("rst_fq_pred_taken", 64'(bus.fq_pred_taken), 64'(0));
    check("rst_fq_pred_target", 64'(bus.fq_pred_target), 64'(0));
    check("rst_fq_ghsr", 64'(bus.fq_ghsr), 64'(0));
    check("rst_pc", 64'(bus.imem_req_addr), 64'(PC_INIT));
    @(negedge clk);
    reset_n = 1'b1;

    // Sequential fetch, 1-cycle memory
    repeat (8) cycle();

    // Predicted taken at 0x8 -> 0x100
    bp_en = 1'b1;
    redirect(32'h0);
    repeat (8) cycle();
    bp_en = 1'b0;

    // Decode backpressure fills the queue exactly
    lat = 2;
    bus.fq_ready = 1'b0;
    repeat (10) cycle();
    #1;
    check("bp_full_count", 64'(bus.fq_count), 64'(FQ_DEPTH));
    check("bp_req_low", 64'(bus.imem_req), 64'(0));
    bus.fq_ready = 1'b1;
    repeat (12) cycle();

    // Redirect with two requests in flight
    lat = 3;
    for (int i = 0; i < 20 && out_m != 2; i++) cycle();
    if (out_m != 2) timeout_fail("setup_two_outstanding");
    redirect(32'h200);
    repeat (12) cycle();

    // Redirect coinciding with a response and a pop
    lat = 2;
    for (int i = 0; i < 20 && !(sb.size() != 0 && mem_q.size() != 0 && mem_q[0].due <= cyc); i++)
      cycle();
    if (!(sb.size() != 0 && mem_q.size() != 0 && mem_q[0].due <= cyc))
      timeout_fail("setup_redirect_resp_pop");
    redirect(32'h300);
    repeat (10) cycle();

    // Asynchronous reset in the middle of a burst
    repeat (3) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_imem_req", 64'(bus.imem_req), 64'(0));
    check("arst_fq_valid", 64'(bus.fq_valid), 64'(0));
    check("arst_fq_count", 64'(bus.fq_count), 64'(0));
    mem_q.delete();
    sb.delete();
    out_m = 0;
    pc_m  = PC_INIT;
    bus.imem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_req", 64'(bus.imem_req), 64'(1));
    check("post_rst_addr", 64'(bus.imem_req_addr), 64'(PC_INIT));
    repeat (8) cycle();

    // Drain
    gnt_en = 1'b0;
    for (int i = 0; i < 20 && (sb.size() != 0 || mem_q.size() != 0); i++) cycle();
    #1;
    check("drain_fq_count", 64'(bus.fq_count), 64'(0));
    check("drain_fq_valid", 64'(bus.fq_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time %0t expected finish", $time);
    $fatal(1, "bench did not finish");
  end
endmodule
